// File: rtl/fb_write_arbiter.sv
// Four-channel sprite write arbiter for a framebuffer port.
// Channels are granted round-robin and keep the grant for a whole sprite burst
// (until req_last or MAX_BURST transfers). Accepted pixels are written one cycle
// later; pixels outside the visible area are consumed and counted instead.
module fb_write_arbiter #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int MAX_BURST = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  input  logic [3:0][9:0]  req_x,
  input  logic [3:0][9:0]  req_y,
  input  logic [3:0][7:0]  req_data,
  output logic [3:0]       req_ready,
  output logic             wr_en,
  output logic [9:0]       wr_x,
  output logic [9:0]       wr_y,
  output logic [7:0]       wr_data,
  output logic [1:0]       owner,
  output logic             busy,
  output logic [15:0]      drop_count
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // 11-bit limits so a resolution of exactly 1024 still compares correctly.
  localparam logic [10:0] H_LIM    = 11'(H_RES);
  localparam logic [10:0] V_LIM    = 11'(V_RES);
  localparam logic [8:0]  CNT_LAST = 9'(MAX_BURST - 1);

  state_t      state, state_next;
  logic [1:0]  rr_ptr;
  logic [8:0]  burst_cnt;
  logic [3:0]  rot_valid;
  logic [1:0]  sel_offset;
  logic [1:0]  sel_ch;
  logic        any_valid;
  logic        accept;
  logic        burst_end;
  logic        in_range;

  // Request vector rotated so that bit 0 is the channel at the round-robin pointer.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_valid[gi] = req_valid[rr_ptr + 2'(gi)];
    end
  endgenerate

  // First requester at or after the pointer wins.
  always_comb begin
    sel_offset = 2'd0;
    if (rot_valid[0])      sel_offset = 2'd0;
    else if (rot_valid[1]) sel_offset = 2'd1;
    else if (rot_valid[2]) sel_offset = 2'd2;
    else if (rot_valid[3]) sel_offset = 2'd3;
  end

  assign sel_ch    = rr_ptr + sel_offset;
  assign any_valid = |req_valid;
  // Only the owner's valid/last matter; other channels' last bits are ignored.
  assign accept    = (state == BURST) && req_valid[owner];
  assign burst_end = accept && (req_last[owner] || (burst_cnt == CNT_LAST));
  assign in_range  = ({1'b0, req_x[owner]} < H_LIM) && ({1'b0, req_y[owner]} < V_LIM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: one arbitration cycle in IDLE, hold BURST until the sprite ends.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = BURST;
      BURST:   if (burst_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: only the owner may transfer, and only during BURST.
  always_comb begin
    busy      = (state == BURST);
    req_ready = 4'b0000;
    if (state == BURST) req_ready = 4'b0001 << owner;
  end

  // Grant bookkeeping: owner latched at arbitration, pointer advanced at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      burst_cnt <= 9'd0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        owner     <= sel_ch;
        burst_cnt <= 9'd0;
      end
    end else if (accept) begin
      burst_cnt <= burst_cnt + 9'd1;
      if (burst_end) rr_ptr <= owner + 2'd1;
    end
  end

  // Write port and drop counter: accepted pixel lands one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_x       <= 10'd0;
      wr_y       <= 10'd0;
      wr_data    <= 8'd0;
      drop_count <= 16'd0;
    end else begin
      wr_en <= accept && in_range;
      if (accept) begin
        wr_x    <= req_x[owner];
        wr_y    <= req_y[owner];
        wr_data <= req_data[owner];
        if (!in_range && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomised and directed bench for fb_write_arbiter. Each channel owns a queue
// of sprite pixels; a transaction-level model of the grant rules predicts
// req_ready, the write port, busy/owner and drop_count every cycle.
module tb_fb_write_arbiter;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int MAX_BURST = 256;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] d;
    logic       last;
  } pix_t;

  logic            clk, rst_n;
  logic [3:0]      req_valid, req_last, req_ready;
  logic [3:0][9:0] req_x, req_y;
  logic [3:0][7:0] req_data;
  logic            wr_en, busy;
  logic [9:0]      wr_x, wr_y;
  logic [7:0]      wr_data;
  logic [1:0]      owner;
  logic [15:0]     drop_count;

  fb_write_arbiter #(.H_RES(H_RES), .V_RES(V_RES), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .owner(owner), .busy(busy), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pending pixels per channel
  pix_t q [4][$];

  // Reference model state
  bit   m_busy;
  int   m_owner, m_ptr, m_cnt, m_drops;
  bit   exp_wr_en;
  int   exp_x, exp_y, exp_d;
  bit   gaps;

  // Observations of the DUT
  int   cyc;
  bit   prev_busy;
  int   n_writes;
  int   last_wx, last_wy;
  int   grant_log[$];
  int   grant_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_drops = 0;
    exp_wr_en = 0; exp_x = 0; exp_y = 0; exp_d = 0;
  endtask

  // One rising edge of the arbiter, described at sprite/pixel level.
  task automatic model_edge();
    pix_t p;
    exp_wr_en = 0;
    if (!m_busy) begin
      if (req_valid != 4'b0) begin
        for (int k = 3; k >= 0; k--)
          if (req_valid[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (req_valid[m_owner]) begin
      p = q[m_owner].pop_front();
      m_cnt++;
      if (p.x < H_RES && p.y < V_RES) begin
        exp_wr_en = 1; exp_x = p.x; exp_y = p.y; exp_d = p.d;
      end else if (m_drops < 65535) begin
        m_drops++;
      end
      if (p.last || m_cnt == MAX_BURST) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 4;
      end
    end
  endtask

  task automatic check_outputs();
    check("wr_en", wr_en, exp_wr_en);
    if (exp_wr_en) begin
      check("wr_x", wr_x, exp_x);
      check("wr_y", wr_y, exp_y);
      check("wr_data", wr_data, exp_d);
    end
    check("busy", busy, m_busy);
    if (m_busy) check("owner", owner, m_owner);
    check("drop_count", drop_count, m_drops);
    if (wr_en) begin
      n_writes++; last_wx = wr_x; last_wy = wr_y;
    end
    if (busy && !prev_busy) begin
      grant_log.push_back(owner);
      grant_cyc.push_back(cyc);
    end
    prev_busy = busy;
    cyc++;
  endtask

  task automatic drive_and_predict();
    logic [3:0] exp_ready;
    for (int c = 0; c < 4; c++) begin
      if (q[c].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        req_valid[c] = 1'b1;
        req_x[c]     = q[c][0].x;
        req_y[c]     = q[c][0].y;
        req_data[c]  = q[c][0].d;
        req_last[c]  = q[c][0].last;
      end else begin
        req_valid[c] = 1'b0;
        req_x[c]     = 10'($urandom);
        req_y[c]     = 10'($urandom);
        req_data[c]  = 8'($urandom);
        req_last[c]  = 1'($urandom);
      end
    end
    #1;
    exp_ready = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    check("req_ready", req_ready, exp_ready);
    model_edge();
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    drive_and_predict();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_x"}, wr_x, 0);
    check({tag, "_wr_y"}, wr_y, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    prev_busy = 0;
    check_outputs();
    drive_and_predict();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b0;
    #1;
    check_zero("rst");
    model_reset();
    for (int c = 0; c < 4; c++) q[c].delete();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  task automatic clear_obs();
    grant_log.delete();
    grant_cyc.delete();
    n_writes = 0;
  endtask

  task automatic push_sprite(input int ch, input int n, input int x0, input int y0,
                             input int d, input bit with_last);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.x = 10'(x0 + i % 16);
      p.y = 10'(y0 + i / 16);
      p.d = 8'(d);
      p.last = with_last && (i == n - 1);
      q[ch].push_back(p);
    end
  endtask

  task automatic drain(input int bound);
    int n;
    int left;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && n < bound) begin
      step();
      n++;
    end
    left = q[0].size() + q[1].size() + q[2].size() + q[3].size();
    check("drain_left", left, 0);
    for (int c = 0; c < 4; c++) q[c].delete();
    repeat (3) step();
  endtask

  task automatic check_grants(input string tag, input int n_exp, input int e[5]);
    check({tag, "_grants"}, grant_log.size(), n_exp);
    for (int i = 0; i < n_exp && i < grant_log.size() && i < 5; i++)
      check({tag, "_owner_seq"}, grant_log[i], e[i]);
  endtask

  initial begin
    pix_t p;
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_data = '0;
    gaps = 0; cyc = 0; prev_busy = 0; n_writes = 0; last_wx = 0; last_wy = 0;
    model_reset();
    #12;
    check_zero("por");

    // Single 256-pixel sprite on ch1, then ch1 and ch2 compete: pointer is now 2.
    do_reset();
    clear_obs();
    push_sprite(1, 256, 100, 50, 8'h3C, 1);
    drain(400);
    check("single_writes", n_writes, 256);
    push_sprite(1, 2, 0, 0, 8'h11, 1);
    push_sprite(2, 2, 0, 0, 8'h22, 1);
    drain(50);
    check_grants("single", 3, '{1, 2, 1, 0, 0});

    // Contention between ch0 (two sprites) and ch2 after reset.
    do_reset();
    clear_obs();
    push_sprite(0, 10, 10, 10, 8'hA0, 1);
    push_sprite(0, 10, 30, 10, 8'hA1, 1);
    push_sprite(2, 10, 50, 10, 8'hA2, 1);
    drain(100);
    check_grants("contend", 3, '{0, 2, 0, 0, 0});

    // Fairness: every channel continuously requesting 4-pixel sprites.
    do_reset();
    clear_obs();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) push_sprite(c, 4, c * 20, r * 20, c + 16 * r, 1);
    drain(100);
    check_grants("fair", 8, '{0, 1, 2, 3, 0});
    for (int i = 1; i < 5 && i < grant_cyc.size(); i++)
      check("fair_period", grant_cyc[i] - grant_cyc[i-1], 5);

    // Overrun: ch3 streams 300 pixels without last; others get their turns between.
    do_reset();
    clear_obs();
    push_sprite(0, 5, 0, 0, 8'h01, 1);
    push_sprite(0, 5, 0, 0, 8'h02, 1);
    push_sprite(1, 5, 0, 0, 8'h03, 1);
    push_sprite(3, 300, 200, 100, 8'h5A, 0);
    drain(600);
    check_grants("overrun", 5, '{0, 1, 3, 0, 3});
    check("overrun_writes", n_writes, 315);

    // Out-of-range pixels are consumed and counted, not written.
    do_reset();
    clear_obs();
    p = '{x: 10'd640, y: 10'd0,   d: 8'h77, last: 1'b0}; q[0].push_back(p);
    p = '{x: 10'd0,   y: 10'd480, d: 8'h78, last: 1'b0}; q[0].push_back(p);
    p = '{x: 10'd639, y: 10'd479, d: 8'h79, last: 1'b1}; q[0].push_back(p);
    drain(20);
    check("oor_drops", drop_count, 2);
    check("oor_writes", n_writes, 1);
    check("oor_wx", last_wx, 639);
    check("oor_wy", last_wy, 479);

    // Reset while ch1 is mid-sprite; the pixel accepted just before must vanish.
    do_reset();
    clear_obs();
    push_sprite(1, 200, 300, 200, 8'hC3, 1);
    repeat (3) step();
    push_sprite(0, 3, 5, 5, 8'h0F, 1);
    for (int n = 0; n < 300 && !(m_busy && m_owner == 1 && m_cnt == 100); n++) step();
    check("midrst_count", m_cnt, 100);
    @(posedge clk);
    #2;
    check("midrst_pre_wr", wr_en, exp_wr_en);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    clear_obs();
    release_reset();
    drain(300);
    check_grants("midrst", 2, '{0, 1, 0, 0, 0});

    // Random sprites with random valid gaps, including some longer than MAX_BURST.
    do_reset();
    gaps = 1;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 8; s++) begin
        int ch;
        int len;
        ch  = $urandom_range(0, 3);
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(257, 280) : $urandom_range(1, 30);
        push_sprite(ch, len, $urandom_range(0, 700), $urandom_range(0, 520),
                    $urandom_range(0, 255), 1);
      end
      drain(6000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
